// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one 32-bit adder between NREQ requesters.
// Latency: 2 edges from sampled request to res_valid/result (grant visible after 1 edge).
// Backpressure: none; one grant per cycle, consumers must take res_valid when it pulses.
//
// Optional feature macro: ADDER_ARB_OVF_EN (builds the registered signed-overflow flag;
// when undefined, ovf is tied to 0).
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester level request (NREQ bits)
//   a_in/b_in  packed operands, requester i at [32i+31:32i]
//   gnt        registered one-hot grant, one cycle
//   res_valid  result strobe, one cycle
//   res_id     requester index owning result
//   result     registered a+b mod 2^32
//   ovf        registered signed overflow of result (0 when feature disabled)

module adder_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c
);
  // Carry out is intentionally dropped: wrap-around arithmetic.
  assign c = a + b;
endmodule

module adder_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*32-1:0]  a_in,
  input  logic [NREQ*32-1:0]  b_in,
  output logic [NREQ-1:0]     gnt,
  output logic                res_valid,
  output logic [IDW-1:0]      res_id,
  output logic [31:0]         result,
  output logic                ovf
);

  // Stage-1 state: priority pointer, captured operands and owner.
  logic [IDW-1:0] ptr;
  logic [31:0]    op_a;
  logic [31:0]    op_b;
  logic [IDW-1:0] s1_id;
  logic           s1_vld;
  logic [31:0]    sum;

  // Arbitration results for the current cycle.
  logic            win_found;
  int              win_idx;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  ptr_nxt;
  logic [NREQ-1:0] gnt_nxt;

  adder_32b u_adder (
    .a (op_a),
    .b (op_b),
    .c (sum)
  );

  // Scan ptr, ptr+1, ... wrapping at NREQ; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    win_id  = IDW'(win_idx);
    // Pointer moves just past the winner so it gets lowest priority next time.
    ptr_nxt = (win_idx == NREQ - 1) ? '0 : IDW'(win_idx + 1);
    gnt_nxt = '0;
    if (win_found) begin
      gnt_nxt[win_idx] = 1'b1;
    end
  end

  // Stage 1: arbitrate and capture operands into the shared adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= '0;
      s1_vld <= 1'b0;
      ptr    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      s1_id  <= '0;
    end else begin
      gnt    <= gnt_nxt;
      s1_vld <= win_found;
      if (win_found) begin
        op_a  <= a_in[win_idx*32 +: 32];
        op_b  <= b_in[win_idx*32 +: 32];
        s1_id <= win_id;
        ptr   <= ptr_nxt;
      end
    end
  end

  // Stage 2: register the adder output; result/res_id hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      result    <= '0;
    end else begin
      res_valid <= s1_vld;
      if (s1_vld) begin
        result <= sum;
        res_id <= s1_id;
      end
    end
  end

`ifdef ADDER_ARB_OVF_EN
  // Signed overflow: like-signed operands producing a sum of the other sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (s1_vld) begin
      ovf <= (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: drives a 2-requester and a 4-requester adder_arbiter from shared stimulus.
// Latency: expected results are queued at the grant edge and due one edge later.
// Backpressure: none; results are checked in the exact cycle they are due.

module tb_adder_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req4;
  logic [127:0] a4;
  logic [127:0] b4;

  logic [1:0]   gnt2;
  logic         rv2;
  logic [1:0]   id2;
  logic [31:0]  res2;
  logic         ovf2;

  logic [3:0]   gnt4;
  logic         rv4;
  logic [1:0]   id4;
  logic [31:0]  res4;
  logic         ovf4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];

  int          ptr_m   [2];
  logic [31:0] last_res[2];
  logic [1:0]  last_id [2];
  logic        last_ovf[2];

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(2), .IDW(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .req       (req4[1:0]),
    .a_in      (a4[63:0]),
    .b_in      (b4[63:0]),
    .gnt       (gnt2),
    .res_valid (rv2),
    .res_id    (id2),
    .result    (res2),
    .ovf       (ovf2)
  );

  adder_arbiter #(.NREQ(4), .IDW(2)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .req       (req4),
    .a_in      (a4),
    .b_in      (b4),
    .gnt       (gnt4),
    .res_valid (rv4),
    .res_id    (id4),
    .result    (res4),
    .ovf       (ovf4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
`ifdef ADDER_ARB_OVF_EN
    return (a[31] == b[31]) && (s[31] != a[31]);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model for one instance, evaluated just after each rising edge.
  task automatic eval(input int k, input logic r, input logic [3:0] rq,
                      input logic [127:0] a, input logic [127:0] b,
                      input logic [3:0] g, input logic rv, input logic [1:0] id,
                      input logic [31:0] res, input logic ov);
    string sfx;
    int    n;
    int    w;
    logic  have;
    exp_t  e;
    sfx = (k == 0) ? "_n2" : "_n4";
    n   = (k == 0) ? 2 : 4;
    if (r) begin
      check_val({"rst_gnt", sfx}, 32'(g), 32'd0);
      check_val({"rst_vld", sfx}, 32'(rv), 32'd0);
      check_val({"rst_id", sfx}, 32'(id), 32'd0);
      check_val({"rst_res", sfx}, res, 32'd0);
      check_val({"rst_ovf", sfx}, 32'(ov), 32'd0);
      ptr_m[k]    = 0;
      last_res[k] = '0;
      last_id[k]  = '0;
      last_ovf[k] = 1'b0;
      if (k == 0) q2.delete(); else q4.delete();
    end else begin
      have = 1'b0;
      if (k == 0 && q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); have = 1'b1; end
      if (k == 1 && q4.size() > 0 && q4[0].due == cyc) begin e = q4.pop_front(); have = 1'b1; end
      check_val({"res_valid", sfx}, 32'(rv), 32'(have));
      if (have) begin
        last_res[k] = e.sum;
        last_id[k]  = e.id;
        last_ovf[k] = e.ovf;
      end
      check_val({"result", sfx}, res, last_res[k]);
      check_val({"res_id", sfx}, 32'(id), 32'(last_id[k]));
      check_val({"ovf", sfx}, 32'(ov), 32'(last_ovf[k]));

      w = -1;
      for (int i = 0; i < n; i++) begin
        int idx;
        idx = (ptr_m[k] + i) % n;
        if (w < 0 && rq[idx]) w = idx;
      end
      check_val({"gnt", sfx}, 32'(g), (w >= 0) ? (32'd1 << w) : 32'd0);
      if (w >= 0) begin
        e.due = cyc + 1;
        e.id  = 2'(w);
        e.sum = a[w*32 +: 32] + b[w*32 +: 32];
        e.ovf = exp_ovf(a[w*32 +: 32], b[w*32 +: 32], e.sum);
        if (k == 0) q2.push_back(e); else q4.push_back(e);
        ptr_m[k] = (w + 1) % n;
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [127:0] a, input logic [127:0] b);
    rst  = r;
    req4 = rq;
    a4   = a;
    b4   = b;
    @(posedge clk);
    #1;
    cyc++;
    eval(0, r, rq, a, b, {2'b00, gnt2}, rv2, id2, res2, ovf2);
    eval(1, r, rq, a, b, gnt4, rv4, id4, res4, ovf4);
  endtask

  initial begin
    rst  = 1'b1;
    req4 = '0;
    a4   = '0;
    b4   = '0;

    // Reset held two cycles with every request high; first grant afterwards is requester 0.
    step(1'b1, 4'hF, {4{32'd1}}, {4{32'd2}});
    step(1'b1, 4'hF, {4{32'd1}}, {4{32'd2}});
    step(1'b0, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd10}});
    step(1'b0, 4'h0, '0, '0);
    step(1'b0, 4'h0, '0, '0);

    // Single add: 10 + (-2) = 8.
    step(1'b0, 4'b0001, {96'd0, 32'd10}, {96'd0, 32'hFFFF_FFFE});
    step(1'b0, 4'h0, '0, '0);
    step(1'b0, 4'h0, '0, '0);

    // Contention between requesters 0 and 1.
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'b0011, {64'd0, 32'd100, 32'd5}, {64'd0, 32'hFFFF_FFFF, 32'd7});
    step(1'b0, 4'h0, '0, '0);

    // Signed overflow and unsigned wrap.
    step(1'b0, 4'b0001, {96'd0, 32'h7FFF_FFFF}, {96'd0, 32'd1});
    step(1'b0, 4'b0001, {96'd0, 32'hFFFF_FFFF}, {96'd0, 32'd1});
    step(1'b0, 4'b0001, {96'd0, 32'h8000_0000}, {96'd0, 32'h8000_0000});
    step(1'b0, 4'h0, '0, '0);
    step(1'b0, 4'h0, '0, '0);

    // Reset one edge after a grant: the capture is dropped and the pointer returns to 0.
    step(1'b0, 4'b0001, {96'd0, 32'd21}, {96'd0, 32'd21});
    step(1'b1, 4'h0, '0, '0);
    step(1'b0, 4'h0, '0, '0);
    step(1'b0, 4'h0, '0, '0);
    step(1'b0, 4'b0011, {64'd0, 32'd2, 32'd1}, {64'd0, 32'd20, 32'd10});
    step(1'b0, 4'h0, '0, '0);

    // Sparse then full request patterns for rotation and wrap of the pointer.
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'b1010, {32'd40, 32'd30, 32'd20, 32'd10}, {32'd4, 32'd3, 32'd2, 32'd1});
    for (int i = 0; i < 6; i++)
      step(1'b0, 4'b1111, {32'd40, 32'd30, 32'd20, 32'd10}, {32'd4, 32'd3, 32'd2, 32'd1});
    step(1'b0, 4'h0, '0, '0);

    // Random requests and operands.
    for (int i = 0; i < 40; i++)
      step(1'b0, 4'($urandom_range(0, 15)),
           {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom});
    step(1'b0, 4'h0, '0, '0);
    step(1'b0, 4'h0, '0, '0);

    check_val("drain_n2", 32'(q2.size()), 32'd0);
    check_val("drain_n4", 32'(q4.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and two-stage sequencer that shares one `adder_32b` instance between up to four requesters in the MIPS datapath (e.g. PC increment, branch-target add, ALU immediate add). It accepts one add per clock from the highest-priority pending requester, registers the operands into the shared adder, and returns a registered, tagged result one cycle later.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `IDW`, default 2: width of requester ID; must satisfy 2^IDW ≥ NREQ.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  NREQ  per-requester add request, level.
- `a_in`  input  NREQ*32  operand A; requester i occupies bits [32i+31:32i].
- `b_in`  input  NREQ*32  operand B, same packing.
- `gnt`  output  NREQ  one-hot grant, registered, high for one cycle.
- `res_valid`  output  1  result strobe, one cycle.
- `res_id`  output  IDW  index of the requester owning `result`.
- `result`  output  32  registered sum `a + b` mod 2^32.
- `ovf`  output  1  signed overflow of `result` (see Configuration).

## Operation
- Stage 1 (arbitrate/capture): on each edge with any `req` bit set, pick the winner by round-robin from priority pointer `ptr`, i.e. the first set bit scanning `ptr`, `ptr+1`, …, wrapping at NREQ. Register `gnt` one-hot for the winner, latch its `a_in`/`b_in` into operand registers driving `adder_32b.a`/`.b`, latch winner ID, set stage-1 valid. Set `ptr` to winner+1 (wraps NREQ-1 → 0).
- No `req` set: `gnt` = 0, stage-1 valid = 0, `ptr` unchanged.
- Stage 2 (result): on each edge, `result` ← `adder_32b.c`, `res_id` ← latched ID, `res_valid` ← stage-1 valid. When `res_valid` = 0, `result`/`res_id` hold their previous values.
- Fully pipelined: one grant per cycle, no stalls, no backpressure; consumers must take `res_valid` when it pulses.
- Requester protocol: hold `req` and operands stable until `gnt[i]` is seen. `req[i]` still high at the edge following `gnt[i]` counts as a new request.
- Arithmetic: plain two's-complement add, carry out discarded. 0xFFFFFFFF + 1 = 0x00000000.
- Reset: `gnt` = 0, `res_valid` = 0, `res_id` = 0, `result` = 0, `ovf` = 0, operand registers = 0, stage-1 valid = 0, `ptr` = 0. `rst` overrides all requests that same edge.
- Reset mid-operation: any in-flight capture is discarded and no `res_valid` follows.
- Requests with index ≥ NREQ do not exist; there is no error state.

## Timing
- Request sampled at edge k → `gnt[i]` high in cycle k..k+1 → `res_valid` = 1 with matching `result`/`res_id` in cycle k+1..k+2. Latency is 2 edges from request to result.
- Back-to-back: continuous requests yield `res_valid` high every cycle.
- All requesters held high continuously are granted in rotation 0,1,…,NREQ-1,0,…, one per cycle. Worst-case wait is NREQ-1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ADDER_ARB_OVF_EN` defined: `ovf` is registered alongside `result` and equals (sign(a)==sign(b)) && (sign(result)≠sign(a)) for the captured operands. It is valid when `res_valid` = 1 and holds otherwise.
- Undefined: no overflow logic is built and `ovf` is tied to 0.

## Test plan
- Reset: assert `rst` 2 cycles with `req` all high → every output is 0 throughout, and the first grant after release goes to requester 0.
- Single add: requester 0 with a=10, b=-2 (0xFFFFFFFE) → `gnt`=01 after 1 edge; `res_valid`=1, `result`=8, `res_id`=0 after 2 edges; `ovf`=0.
- Contention: `req`=11 held for 4 cycles, requester 0 (5+7) and requester 1 (100+(-1)) → grants 01,10,01,10; results 12,99,12,99 with ids 0,1,0,1 on consecutive cycles.
- Wrap and overflow: a=0x7FFFFFFF, b=1 → `result`=0x80000000, `ovf`=1 with the macro and 0 without. a=0xFFFFFFFF, b=1 → `result`=0, `ovf`=0.
- Reset mid-flight: grant issued at edge k, `rst` high at edge k+1 → no `res_valid` follows and `ptr` returns to 0.
- NREQ=4 rotation: `req`=1010 held → grants alternate 0010, 1000; then `req`=1111 → grant order continues from the pointer and wraps correctly.
